// File: rtl/cla_adder.sv
// Two-level-grouped carry-lookahead adder with a one-cycle result register.
// Carries resolve through bit, group, super-group and top lookahead levels.
module cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             overflow
);

  localparam int NG = WIDTH / 4;
  localparam int NS = (NG + 3) / 4;

  // Carries c[1..4] of a 4-wide lookahead block, in flattened sum-of-products form.
  function automatic logic [4:0] la4(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       ci
  );
    logic [4:0] c;
    logic       t;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i < 5; i++) begin
      t = ci;
      for (int m = 0; m < i; m++) t = t & p[m];
      c[i] = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int m = j + 1; m < i; m++) t = t & p[m];
        c[i] = c[i] | t;
      end
    end
    return c;
  endfunction

  logic [WIDTH-1:0]  g, p, sum;
  logic [WIDTH:0]    c;
  logic [4*NS-1:0]   gg, gp, cg;
  logic [NS-1:0]     sg, sp, cs;
  logic [4:0]        tmp;
  logic              t;

  always_comb begin
    g   = A & B;
    p   = A ^ B;
    gg  = '0;
    gp  = '0;
    sg  = '0;
    sp  = '0;
    cs  = '0;
    cg  = '0;
    c   = '0;
    tmp = '0;
    t   = 1'b0;

    for (int k = 0; k < NG; k++) begin
      tmp   = la4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      gg[k] = tmp[4];
      gp[k] = &p[4*k +: 4];
    end

    for (int s = 0; s < NS; s++) begin
      tmp   = la4(gg[4*s +: 4], gp[4*s +: 4], 1'b0);
      sg[s] = tmp[4];
      sp[s] = &gp[4*s +: 4];
    end

    // Top level: carry into each super-group straight from cin and sg/sp.
    cs[0] = cin;
    for (int i = 1; i < NS; i++) begin
      t = cin;
      for (int m = 0; m < i; m++) t = t & sp[m];
      cs[i] = t;
      for (int j = 0; j < i; j++) begin
        t = sg[j];
        for (int m = j + 1; m < i; m++) t = t & sp[m];
        cs[i] = cs[i] | t;
      end
    end

    for (int s = 0; s < NS; s++) begin
      tmp           = la4(gg[4*s +: 4], gp[4*s +: 4], cs[s]);
      cg[4*s +: 4]  = tmp[3:0];
    end

    for (int k = 0; k < NG; k++) begin
      tmp          = la4(g[4*k +: 4], p[4*k +: 4], cg[k]);
      c[4*k +: 5]  = tmp;
    end

    sum = p ^ c[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      S         <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S        <= sum;
        cout     <= c[WIDTH];
        overflow <= c[WIDTH] ^ c[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder: directed vectors, control cases, random sweep.
// Driver pushes expected results; monitor pops on out_valid.
module tb_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] A, B;
  logic        cin;
  logic        out_valid;
  logic [31:0] S;
  logic        cout;
  logic        overflow;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   n_vec = 0;
  int   n_err = 0;

  cla_adder #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .cin      (cin),
    .out_valid(out_valid),
    .S        (S),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] r;
    exp_t        e;
    r   = {1'b0, a} + {1'b0, b} + {32'b0, ci};
    e.s = r[31:0];
    e.c = r[32];
    e.o = (a[31] == b[31]) && (r[31] != a[31]);
    return e;
  endfunction

  task automatic chk(input string name, input exp_t act, input exp_t exp_v,
                     input logic av, input logic ev);
    n_vec++;
    if (act !== exp_v || av !== ev) begin
      n_err++;
      $display("FAIL %s: got S=%h cout=%b ovf=%b vld=%b, want S=%h cout=%b ovf=%b vld=%b",
               name, act.s, act.c, act.o, av, exp_v.s, exp_v.c, exp_v.o, ev);
    end
  endtask

  // Monitor: compare every presented result with the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious: out_valid with empty scoreboard, S=%h", S);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", '{S, cout, overflow}, e, out_valid, 1'b1);
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    A        = a;
    B        = b;
    cin      = ci;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] b, input logic ci,
                     input logic [31:0] es, input logic ec, input logic eo);
    drive(a, b, ci);
    last_exp = '{es, ec, eo};
    q.push_back(last_exp);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    A        = 32'h1234_5678;
    B        = 32'h0F0F_0F0F;
    cin      = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", '{S, cout, overflow}, '{32'h0, 1'b0, 1'b0}, out_valid, 1'b0);

    put(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    put(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    put(32'h00000005, 32'hFFFFFFFD, 1'b0, 32'h00000002, 1'b1, 1'b0);
    put(32'hFFFFFFFC, 32'hFFFFFFF8, 1'b0, 32'hFFFFFFF4, 1'b1, 1'b0);
    put(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    put(32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1);
    put(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
    put(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    put(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
    put(32'h00000007, 32'h0000000A, 1'b0, 32'h00000011, 1'b0, 1'b0);
    put(32'h0000000A, 32'h0000000F, 1'b0, 32'h00000019, 1'b0, 1'b0);
    put(32'h00000017, 32'h00000008, 1'b0, 32'h0000001F, 1'b0, 1'b0);
    put(32'h0000003C, 32'h0000000A, 1'b0, 32'h00000046, 1'b0, 1'b0);

    idle();
    @(negedge clk);
    chk("hold", '{S, cout, overflow}, last_exp, out_valid, 1'b0);

    put(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; A = 32'h1; B = 32'h1; cin = 1'b0;
    @(negedge clk);
    chk("rst_over_valid", '{S, cout, overflow}, '{32'h0, 1'b0, 1'b0}, out_valid, 1'b0);

    put(32'h00000001, 32'h00000002, 1'b1, 32'h00000004, 1'b0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] a, b;
      logic        ci;
      a  = $urandom;
      b  = $urandom;
      ci = 1'($urandom_range(0, 1));
      drive(a, b, ci);
      q.push_back(model(a, b, ci));
    end

    idle();
    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results never presented, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_adder.md
Name: cla_adder

Overview:
- 32-bit two's-complement carry-lookahead adder with registered outputs.
- Computes A + B + cin and produces the sum, the unsigned carry-out and the signed overflow flag.
- Serves as the fast-adder datapath element, interchangeable with the ripple, carry-bypass and carry-select adders behind a one-cycle register boundary.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 (4-bit lookahead groups).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid this cycle; the result is captured when high
- A  input  WIDTH  operand A, two's complement
- B  input  WIDTH  operand B, two's complement
- cin  input  1  carry-in, bit-0 weight
- out_valid  output  1  S, cout and overflow hold a fresh result
- S  output  WIDTH  sum, A + B + cin modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1 (unsigned overflow)
- overflow  output  1  signed overflow flag

Behaviour:
- Combinational core computes carries by lookahead, not by ripple:
  - per-bit generate g_i = A_i & B_i and propagate p_i = A_i ^ B_i;
  - 4-bit CLA groups produce group G/P;
  - a second lookahead level over groups of 4 groups;
  - a top level over the super-groups;
  - sum bit S_i = p_i ^ c_i, with c_0 = cin.
- cout = c_WIDTH.
- overflow = c_WIDTH ^ c_(WIDTH-1). This equals "A and B have the same sign and S has the opposite sign", including the cin contribution.
- Registers: S, cout, overflow and out_valid update only on the rising edge of clk. Latency is exactly 1 cycle from sampled inputs to outputs.
- in_valid = 1 at an edge: capture the combinational result; out_valid <= 1.
- in_valid = 0 at an edge: S, cout and overflow hold their previous values; out_valid <= 0.
- rst = 1 at an edge: S <= 0, cout <= 0, overflow <= 0, out_valid <= 0.
  - rst has priority over in_valid.
  - No async path; outputs are undefined-free only from the first clocked edge.
- Reset mid-stream: the operation sampled on the reset edge is discarded. The first result after reset is for operands presented with in_valid = 1 on the first edge with rst = 0.
- Wrap-around: results are modulo 2^WIDTH. There is no saturation; the overflow and cout flags report the wrap.
- Back-to-back operation: a new operand pair is accepted every cycle, giving a throughput of 1/cycle.
- No X propagation from unused logic: every combinational output is fully determined by A, B and cin.

Test Plan:
- A=7FFFFFFF, B=00000001, cin=0, in_valid=1 -> next cycle S=80000000, cout=0, overflow=1, out_valid=1.
- A=80000000, B=FFFFFFFF, cin=0 -> S=7FFFFFFF, cout=1, overflow=1.
- A=00000005, B=FFFFFFFD -> S=00000002, cout=1, overflow=0. Also A=FFFFFFFC, B=FFFFFFF8 -> S=FFFFFFF4, cout=1, overflow=0.
- Back-to-back pairs 7+A, A+F, 17+8, 3C+A on consecutive cycles -> S=00000011, 00000019, 0000001F, 00000046 on the following consecutive cycles; cout=0, overflow=0 each time.
- Carry-in chain: A=FFFFFFFF, B=00000000, cin=1 -> S=00000000, cout=1, overflow=0. A=7FFFFFFF, B=0, cin=1 -> S=80000000, overflow=1.
- Control:
  - rst=1 together with in_valid=1 -> S=0, cout=0, overflow=0, out_valid=0 on the next edge.
  - in_valid=0 after a result -> S, cout and overflow held, out_valid=0.
  - Random 10k operand/cin vectors compared against a reference computed as (A+B+cin) with 33-bit width.
